fmul32_normalize_round: RTL and testbench

- Post-multiply normalization and rounding stage of the FMUL32 datapath.
- Consumes three items from upstream:
  - the raw unsigned mantissa product;
  - the leading-zero count of that product, from the leading-zero counter stage;
  - the pre-adjusted exponent sum and sign.
- Produces a packed IEEE-754 single-precision result.
- Two-stage valid/ready pipeline:
  - stage 1: normalize shift and exponent adjust;
  - stage 2: round-to-nearest-even, renormalize, range check, pack.

---
 rtl/fmul32_normalize_round.sv | 112 +++++++++++
 tb/tb_fmul32_normalize_round.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fmul32_normalize_round.sv
// FMUL32 post-multiply normalize and round: two-stage valid/ready pipeline
// turning a raw mantissa product plus exponent/sign into a packed single.
module fmul32_normalize_round #(
  parameter int PROD_W = 48,
  parameter int EXP_W  = 10,
  parameter int LZ_W   = $clog2(PROD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [LZ_W-1:0]   in_zero_num,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow
);

  localparam logic signed [EXP_W:0] EMAX = (EXP_W+1)'(255);

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic              r_s1_zero;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [PROD_W-1:0] r_s1_norm;

  logic              r_out_valid;
  logic [31:0]       r_out_result;
  logic              r_out_ovf;
  logic              r_out_udf;

  logic              w_s2_adv;
  logic [PROD_W-1:0] w_norm;
  logic [EXP_W-1:0]  w_e1;
  logic [22:0]       w_frac;
  logic              w_guard;
  logic              w_sticky;
  logic              w_rnd_up;
  logic [23:0]       w_frac_rnd;
  logic signed [EXP_W:0] w_e2;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  // Stage 1: leading-zero count is trusted as given.
  assign w_norm = in_prod << in_zero_num;
  assign w_e1   = in_exp + EXP_W'(1) - EXP_W'(in_zero_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
    end
    if (in_valid && in_ready) begin
      r_s1_sign <= in_sign;
      r_s1_zero <= in_zero || (in_prod == '0);
      r_s1_exp  <= w_e1;
      r_s1_norm <= w_norm;
    end
  end

  // Stage 2: round-to-nearest-even; a carry out of frac bumps the exponent.
  assign w_frac     = r_s1_norm[PROD_W-2 -: 23];
  assign w_guard    = r_s1_norm[PROD_W-25];
  assign w_sticky   = |r_s1_norm[PROD_W-26:0];
  assign w_rnd_up   = w_guard && (w_sticky || w_frac[0]);
  assign w_frac_rnd = {1'b0, w_frac} + {23'b0, w_rnd_up};
  assign w_e2       = $signed({r_s1_exp[EXP_W-1], r_s1_exp})
                    + $signed({{EXP_W{1'b0}}, w_frac_rnd[23]});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 32'h0;
      r_out_ovf    <= 1'b0;
      r_out_udf    <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        if (r_s1_zero) begin
          r_out_result <= {r_s1_sign, 31'h0};
          r_out_ovf    <= 1'b0;
          r_out_udf    <= 1'b0;
        end else if (w_e2 >= EMAX) begin
          r_out_result <= {r_s1_sign, 8'hFF, 23'h0};
          r_out_ovf    <= 1'b1;
          r_out_udf    <= 1'b0;
        end else if (w_e2 <= 0) begin
          r_out_result <= {r_s1_sign, 31'h0};
          r_out_ovf    <= 1'b0;
          r_out_udf    <= 1'b1;
        end else begin
          r_out_result <= {r_s1_sign, w_e2[7:0], w_frac_rnd[22:0]};
          r_out_ovf    <= 1'b0;
          r_out_udf    <= 1'b0;
        end
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_result    = r_out_result;
  assign out_overflow  = r_out_ovf;
  assign out_underflow = r_out_udf;

endmodule

// File: tb/tb_fmul32_normalize_round.sv
// Scoreboard bench for fmul32_normalize_round: driver pushes expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_fmul32_normalize_round;

  localparam int PROD_W = 48;
  localparam int EXP_W  = 10;
  localparam int LZ_W   = $clog2(PROD_W);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [PROD_W-1:0] in_prod;
  logic [LZ_W-1:0]   in_zero_num;
  logic              in_zero;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_overflow;
  logic              out_underflow;

  fmul32_normalize_round #(.PROD_W(PROD_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod),
    .in_zero_num(in_zero_num), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: transfer happens at the next posedge when valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", {out_result, out_overflow, out_underflow}, 34'h0);
        if ({out_result, out_overflow, out_underflow} == 34'h0) n_bad++;
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", {out_result, out_overflow, out_underflow}, {e.res, e.ovf, e.udf});
      end
    end
  end

  task automatic send(input logic s, input logic [EXP_W-1:0] e, input logic [PROD_W-1:0] p,
                      input logic [LZ_W-1:0] zn, input logic z,
                      input logic [31:0] r, input logic ov, input logic uf);
    int t;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_prod = p; in_zero_num = zn; in_zero = z;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        $display("FAIL send_timeout: in_ready stuck at %b expected 1", in_ready);
        n_cmp++; n_bad++;
        break;
      end
    end
    q.push_back('{res: r, ovf: ov, udf: uf});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); t++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain_timeout: %0d results pending expected 0", q.size());
      n_cmp++; n_bad++;
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_prod = '0;
    in_zero_num = '0; in_zero = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    check("reset_out_valid", 34'(out_valid), 34'd0);
    check("reset_outputs", {out_result, out_overflow, out_underflow}, 34'h0);
    check("reset_in_ready", 34'(in_ready), 34'd1);

    // Latency: 1.0*1.0, out_valid rises exactly two edges after transfer.
    send(1'b0, 10'd127, 48'h4000_0000_0000, 6'd1, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    check("latency_1", 34'(out_valid), 34'd0);
    @(posedge clk); #1;
    check("latency_2", 34'(out_valid), 34'd1);
    drain();

    send(1'b1, 10'd127, 48'h9000_0000_0000, 6'd0, 1'b0, 32'hC010_0000, 1'b0, 1'b0);
    send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 6'd1, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    // bit 23 lands in frac lsb after the shift, so no rounding applies
    send(1'b0, 10'd127, 48'h4000_0080_0000, 6'd1, 1'b0, 32'h3F80_0001, 1'b0, 1'b0);
    // exact tie, even lsb: stays
    send(1'b0, 10'd127, 48'h4000_0040_0000, 6'd1, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    // exact tie, odd lsb: rounds to even
    send(1'b0, 10'd127, 48'h4000_00C0_0000, 6'd1, 1'b0, 32'h3F80_0002, 1'b0, 1'b0);
    // below half with sticky only: stays
    send(1'b0, 10'd127, 48'h4000_0000_0001, 6'd1, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    send(1'b0, 10'd255, 48'h4000_0000_0000, 6'd1, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    send(1'b0, 10'd254, 48'h4000_0000_0000, 6'd1, 1'b0, 32'h7F00_0000, 1'b0, 1'b0);
    send(1'b0, 10'd0,   48'h4000_0000_0000, 6'd1, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    send(1'b1, 10'd1,   48'h4000_0000_0000, 6'd1, 1'b0, 32'h8080_0000, 1'b0, 1'b0);
    send(1'b1, 10'd127, 48'h4000_0000_0000, 6'd1, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    send(1'b0, 10'd127, 48'h0,              6'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    drain();

    // Backpressure: two accepted, then in_ready drops.
    out_ready = 1'b0;
    send(1'b0, 10'd127, 48'h4000_0000_0000, 6'd1, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    send(1'b1, 10'd127, 48'h9000_0000_0000, 6'd0, 1'b0, 32'hC010_0000, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_in_ready_low", 34'(in_ready), 34'd0);
    check("bp_hold_result", {out_result, out_overflow, out_underflow}, {32'h3F80_0000, 2'b00});
    fork
      begin
        @(posedge clk); @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join_none
    send(1'b0, 10'd255, 48'h4000_0000_0000, 6'd1, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    send(1'b0, 10'd127, 48'h7FFF_FFC0_0000, 6'd1, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    drain();

    // Reset mid-stream discards in-flight data.
    out_ready = 1'b0;
    send(1'b0, 10'd127, 48'h4000_0000_0000, 6'd1, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    send(1'b0, 10'd128, 48'h4000_0000_0000, 6'd1, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check("rst_mid_out_valid", 34'(out_valid), 34'd0);
    check("rst_mid_in_ready", 34'(in_ready), 34'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_mid_no_stale", 34'(out_valid), 34'd0);
    send(1'b1, 10'd127, 48'h4000_0000_0000, 6'd1, 1'b0, 32'hBF80_0000, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish expected completion");
    $fatal(1, "timeout");
  end

endmodule
